mux_scan_nb: RTL and testbench

MUX_SCAN_NB -- requirements
Module: mux_scan_nb

---
 rtl/mux_scan_nb.sv | 104 ++++++++++
 tb/tb_mux_scan_nb.sv | 134 +++++++++++++
 2 files changed

// File: rtl/mux_scan_nb.sv
// Registered channel selector with manual/scan capture and a one-deep output slot
// with ready/valid handoff. Scan mode walks channels round-robin from a retained pointer.

module mux_scan_nb_lane #(
   parameter int WIDTH = 4,
   parameter int SELW  = 2,
   parameter int IDX   = 0
) (
   input  logic [WIDTH-1:0] ch_data,
   input  logic [SELW-1:0]  sel_ch,
   output logic [WIDTH-1:0] lane_data
);
   // Each lane contributes its data only when selected; the top ORs all lanes.
   assign lane_data = (sel_ch == SELW'(IDX)) ? ch_data : '0;
endmodule

module mux_scan_nb #(
   parameter int WIDTH = 4,
   parameter int SELW  = 2,
   parameter int NCH   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NCH*WIDTH-1:0]  in_data,
   input  logic [SELW-1:0]       sel,
   input  logic                  mode,
   input  logic                  load,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic [SELW-1:0]       out_ch,
   output logic                  out_valid,
   output logic                  scan_wrap
);

   generate
      if (NCH != 2**SELW) begin : g_bad_cfg
         $error("mux_scan_nb: NCH must equal 2**SELW");
      end
   endgenerate

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [SELW-1:0]  ch;
   } sample_t;

   state_t                        state;
   sample_t                       smp;
   logic [SELW-1:0]               scan_ptr;
   logic [SELW-1:0]               sel_ch;
   logic [NCH-1:0][WIDTH-1:0]     lane_q;
   logic [WIDTH-1:0]              ch_data;
   logic                          slot_free;
   logic                          capture;

   assign slot_free = (state == EMPTY) || out_ready;
   assign capture   = slot_free && (mode || load);
   assign sel_ch    = mode ? scan_ptr : sel;

   genvar k;
   generate
      for (k = 0; k < NCH; k++) begin : g_lane
         mux_scan_nb_lane #(.WIDTH(WIDTH), .SELW(SELW), .IDX(k)) u_lane (
            .ch_data   (in_data[k*WIDTH +: WIDTH]),
            .sel_ch    (sel_ch),
            .lane_data (lane_q[k])
         );
      end
   endgenerate

   always_comb begin
      ch_data = '0;
      for (int i = 0; i < NCH; i++) ch_data = ch_data | lane_q[i];
   end

   // Sample registers only move on capture, so they hold through stalls and EMPTY.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= EMPTY;
         smp       <= '0;
         scan_ptr  <= '0;
         scan_wrap <= 1'b0;
      end else begin
         scan_wrap <= 1'b0;
         if (capture) begin
            state    <= FULL;
            smp.data <= ch_data;
            smp.ch   <= sel_ch;
            if (mode) begin
               scan_ptr  <= scan_ptr + 1'b1;
               scan_wrap <= (scan_ptr == SELW'(NCH-1));
            end
         end else if (out_ready) begin
            state <= EMPTY;
         end
      end
   end

   assign out_valid = (state == FULL);
   assign out_data  = smp.data;
   assign out_ch    = smp.ch;

endmodule

// File: tb/tb_mux_scan_nb.sv
// Directed-vector bench for mux_scan_nb: default 4x4 instance plus an 8x8 scan instance.

module tb_mux_scan_nb;
   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // default configuration
   logic        rst, mode, load, out_ready;
   logic [15:0] in_data;
   logic [1:0]  sel;
   logic [3:0]  out_data;
   logic [1:0]  out_ch;
   logic        out_valid, scan_wrap;

   // wide configuration
   logic        rst8, mode8, load8, rdy8;
   logic [63:0] in8;
   logic [2:0]  sel8;
   logic [7:0]  out_data8;
   logic [2:0]  out_ch8;
   logic        out_valid8, scan_wrap8;

   int errs = 0;
   int checks = 0;

   mux_scan_nb dut (
      .clk(clk), .rst(rst), .in_data(in_data), .sel(sel), .mode(mode),
      .load(load), .out_ready(out_ready), .out_data(out_data),
      .out_ch(out_ch), .out_valid(out_valid), .scan_wrap(scan_wrap)
   );

   mux_scan_nb #(.WIDTH(8), .SELW(3), .NCH(8)) dut8 (
      .clk(clk), .rst(rst8), .in_data(in8), .sel(sel8), .mode(mode8),
      .load(load8), .out_ready(rdy8), .out_data(out_data8),
      .out_ch(out_ch8), .out_valid(out_valid8), .scan_wrap(scan_wrap8)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // advance one edge and settle outputs away from it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [3:0] d, input logic [1:0] c,
                          input logic v, input logic w);
      chk({tag, ".data"}, 32'(out_data), 32'(d));
      chk({tag, ".ch"},   32'(out_ch),   32'(c));
      chk({tag, ".valid"},32'(out_valid),32'(v));
      chk({tag, ".wrap"}, 32'(scan_wrap),32'(w));
   endtask

   initial begin
      rst = 1; mode = 0; load = 0; out_ready = 0; in_data = 16'hFFFF; sel = 0;
      rst8 = 1; mode8 = 0; load8 = 0; rdy8 = 0; in8 = '0; sel8 = 0;
      step(); step();
      chk_out("reset", 4'h0, 2'd0, 1'b0, 1'b0);

      // manual capture, one-cycle latency, drains with ready held
      rst = 0; in_data = 16'hDCBA; sel = 2; load = 1; out_ready = 1;
      step();
      chk_out("man_cap", 4'hC, 2'd2, 1'b1, 1'b0);
      load = 0;
      step();
      chk_out("man_drain", 4'hC, 2'd2, 1'b0, 1'b0);

      // backpressure: held sample survives input churn
      sel = 0; load = 1; out_ready = 0;
      step();
      chk_out("bp_fill", 4'hA, 2'd0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         in_data = 16'h5678 + 16'(i); sel = 2'(i + 1); load = (i != 1);
         step();
         chk_out($sformatf("bp_stall%0d", i), 4'hA, 2'd0, 1'b1, 1'b0);
      end
      in_data = 16'hDCBA; out_ready = 1; load = 1; sel = 3;
      step();
      chk_out("bp_release", 4'hD, 2'd3, 1'b1, 1'b0);
      load = 0;
      step();
      chk("bp_empty.valid", 32'(out_valid), 32'd0);

      // scan wrap from ptr 0
      rst = 1; step(); rst = 0;
      mode = 1; out_ready = 1; in_data = 16'h4321;
      for (int i = 0; i < 6; i++) begin
         step();
         chk_out($sformatf("scan%0d", i), 4'((i % 4) + 1), 2'(i % 4), 1'b1, 1'((i % 4) == 3));
      end

      // mode switch retains scan pointer
      rst = 1; mode = 0; step(); rst = 0;
      mode = 1;
      step(); chk_out("ms_scan0", 4'h1, 2'd0, 1'b1, 1'b0);
      step(); chk_out("ms_scan1", 4'h2, 2'd1, 1'b1, 1'b0);
      mode = 0; sel = 0; load = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_out($sformatf("ms_man%0d", i), 4'h1, 2'd0, 1'b1, 1'b0);
      end
      mode = 1; load = 0;
      step(); chk_out("ms_resume", 4'h3, 2'd2, 1'b1, 1'b0);

      // stall with ptr=3, then reset with a pending load
      out_ready = 0;
      step(); chk_out("rs_stall", 4'h3, 2'd2, 1'b1, 1'b0);
      rst = 1; load = 1; mode = 0;
      step(); chk_out("rs_reset", 4'h0, 2'd0, 1'b0, 1'b0);
      rst = 0; load = 0; mode = 1; out_ready = 1;
      step(); chk_out("rs_first", 4'h1, 2'd0, 1'b1, 1'b0);
      mode = 0;
      step();

      // wide configuration, 9 scan captures
      in8 = 64'h8877665544332211; rst8 = 0; mode8 = 1; rdy8 = 1;
      for (int i = 0; i < 9; i++) begin
         step();
         chk($sformatf("w8_%0d.ch", i),   32'(out_ch8),   32'(i % 8));
         chk($sformatf("w8_%0d.data", i), 32'(out_data8), 32'(((i % 8) + 1) * 8'h11));
         chk($sformatf("w8_%0d.wrap", i), 32'(scan_wrap8), 32'((i % 8) == 7));
         chk($sformatf("w8_%0d.valid", i),32'(out_valid8),32'd1);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
